uart_baud_ctrl: RTL
===================

# uart_baud_ctrl

Baud-rate controller for the full UART. Owns the active baud divisor for a 100 MHz clock, accepts run-time baud changes from the host, and defers each change until both transmitter and receiver are disabled. It also generates the TX bit-period tick and the RX mid-bit sampling tick from the active divisor. It sits between the host register interface and the UART TX/RX engines.

## Interface
- RESET_BAUD, 4'b0100, baud code loaded at reset (9600).
- CLK  in  1  system clock, 100 MHz.
- RESET  in  1  synchronous, active-high reset.
- BAUD  in  4  requested baud code, sampled only when BAUD_WR=1.
- BAUD_WR  in  1  one-cycle strobe requesting a baud change.
- TX_EN  in  1  transmitter active; TX tick counter runs while high.
- RX_EN  in  1  receiver active; RX tick counter runs while high.
- RX_SYNC  in  1  start-bit edge; restarts the RX phase.
- TX_TICK  out  1  one-cycle pulse per bit period.
- RX_TICK  out  1  one-cycle pulse at each bit centre.
- BAUD_CUR  out  4  active baud code.
- DIVISOR  out  19  active divisor D.
- CFG_PEND  out  1  a change is waiting for TX/RX idle.
- CFG_ACK  out  1  one-cycle pulse when a change takes effect.

## Operation
- Divisor table (code -> D), applied combinationally to the pending code:
  - 0 -> 333333, 1 -> 83333, 2 -> 41667, 3 -> 20833
  - 4 -> 10417, 5 -> 5208, 6 -> 2604, 7 -> 1736
  - 8 -> 868, 9 -> 434, 10 -> 217, 11 -> 109
  - codes 12-15 -> 333333 (BAUD_CUR still reports the written code)
- The config FSM has three states: IDLE, PEND and APPLY.
  - IDLE, BAUD_WR=1: capture BAUD into the pending register, go to PEND.
  - PEND, BAUD_WR=1: overwrite the pending code (last write wins). Stay in PEND.
  - PEND, TX_EN=0 and RX_EN=0, no BAUD_WR in that cycle: go to APPLY.
  - APPLY: load BAUD_CUR and DIVISOR from the pending code, pulse CFG_ACK. Go to IDLE, or to PEND if BAUD_WR=1 in the same cycle (the new code is captured).
- CFG_PEND=1 in PEND, otherwise 0.
- TX counter (19 bits):
  - Cleared while TX_EN=0. Increments while TX_EN=1.
  - When the count reaches D-1, the counter wraps to 0 and TX_TICK is registered high for the next cycle.
- RX counter (19 bits):
  - Cleared while RX_EN=0, or when RX_SYNC=1.
  - Counts to a target, then reloads and pulses RX_TICK.
  - The first target after clear is (D>>1)-1. Every later target is D-1.
- The ticks always use the active DIVISOR. A pending change never alters tick spacing.
- Reset values: BAUD_CUR=RESET_BAUD, DIVISOR=10417, both counters 0, FSM=IDLE, pending register=RESET_BAUD, all pulse outputs 0, CFG_PEND=0.

## Timing
- TX_EN first sampled high at edge 0: TX_TICK is high in the cycles following edges D, 2D, 3D, …
- RX_EN high, or RX_SYNC pulsed, at edge 0 (with RX_EN high): first RX_TICK after edge D>>1, then every D edges.
- RX_SYNC coincident with an RX_TICK restarts the phase. That tick still appears; the next one is D>>1 later.
- TX_EN or RX_EN dropping mid-period clears its counter on the next edge. No tick is emitted for the partial period.
- Change latency with TX and RX idle:
  - BAUD_WR at edge n.
  - CFG_PEND is high after edge n.
  - The APPLY state is entered at edge n+1.
  - DIVISOR, BAUD_CUR and CFG_ACK change after edge n+2.
- If either enable is high, the change is held in PEND indefinitely. APPLY follows one edge after both enables are sampled low.
- If TX_EN or RX_EN rises during APPLY, its counter uses the newly loaded DIVISOR from its first count.
- RESET has priority over all inputs. RESET during PEND or APPLY discards the pending change with no CFG_ACK.

## Test plan
- Reset defaults: assert RESET for 3 cycles -> BAUD_CUR=4, DIVISOR=10417, all ticks, CFG_PEND and CFG_ACK = 0.
- Idle baud change: BAUD=8 with BAUD_WR while TX_EN=RX_EN=0 -> CFG_ACK pulses 2 cycles after the write. DIVISOR=868, BAUD_CUR=8.
- Deferred change: TX_EN=1, write BAUD=11 -> CFG_PEND=1 and TX_TICK stays at 10417-cycle spacing. Drop TX_EN -> CFG_ACK, DIVISOR=109.
- Tick spacing: code 10 active, TX_EN=1 for 1000 cycles -> TX_TICK at edges 217, 434, 651, 868.
- RX phase: code 10, RX_EN rises, RX_SYNC pulsed at edge 300 -> RX_TICK at edges 108, 408, 625.
- Overwrite, out-of-range code and reset abort:
  - Writes of 3 then 13 while pending -> the apply yields BAUD_CUR=13, DIVISOR=333333.
  - RESET asserted while pending -> no CFG_ACK, BAUD_CUR=4.

Source files
------------

// File: rtl/uart_baud_ctrl_if.sv
// Host/engine-facing signal bundle for the UART baud controller.
// master drives the requests and enables; slave is the controller's own view.
interface uart_baud_ctrl_if;
  localparam int unsigned CODE_W = 4;
  localparam int unsigned DIV_W  = 19;

  logic [CODE_W-1:0] baud;
  logic              baud_wr;
  logic              tx_en;
  logic              rx_en;
  logic              rx_sync;
  logic              tx_tick;
  logic              rx_tick;
  logic [CODE_W-1:0] baud_cur;
  logic [DIV_W-1:0]  divisor;
  logic              cfg_pend;
  logic              cfg_ack;

  modport master (
    output baud, baud_wr, tx_en, rx_en, rx_sync,
    input  tx_tick, rx_tick, baud_cur, divisor, cfg_pend, cfg_ack
  );

  modport slave (
    input  baud, baud_wr, tx_en, rx_en, rx_sync,
    output tx_tick, rx_tick, baud_cur, divisor, cfg_pend, cfg_ack
  );
endinterface

// File: rtl/uart_baud_ctrl.sv
// Baud-rate controller: holds the active divisor, defers host baud changes until
// TX and RX are both idle, and generates the TX bit tick and RX mid-bit tick.
module uart_baud_ctrl #(
  parameter logic [3:0] RESET_BAUD = 4'b0100
) (
  input  logic            clk,
  input  logic            reset,
  uart_baud_ctrl_if.slave bus
);
  localparam int unsigned CODE_W = 4;
  localparam int unsigned DIV_W  = 19;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    APPLY = 2'd2
  } cfg_state_t;

  // Baud code to clock divisor for a 100 MHz clock; unused codes fall back to the slowest rate.
  function automatic logic [DIV_W-1:0] div_lut(input logic [CODE_W-1:0] code);
    case (code)
      4'd0:    div_lut = DIV_W'(333333);
      4'd1:    div_lut = DIV_W'(83333);
      4'd2:    div_lut = DIV_W'(41667);
      4'd3:    div_lut = DIV_W'(20833);
      4'd4:    div_lut = DIV_W'(10417);
      4'd5:    div_lut = DIV_W'(5208);
      4'd6:    div_lut = DIV_W'(2604);
      4'd7:    div_lut = DIV_W'(1736);
      4'd8:    div_lut = DIV_W'(868);
      4'd9:    div_lut = DIV_W'(434);
      4'd10:   div_lut = DIV_W'(217);
      4'd11:   div_lut = DIV_W'(109);
      default: div_lut = DIV_W'(333333);
    endcase
  endfunction

  cfg_state_t        state;
  logic [CODE_W-1:0] pend_code;
  logic [DIV_W-1:0]  pend_div;
  logic [CODE_W-1:0] baud_cur;
  logic [DIV_W-1:0]  divisor;
  logic              cfg_pend;
  logic              cfg_ack;

  logic [DIV_W-1:0]  tx_cnt;
  logic              tx_run;
  logic              tx_tick;
  logic [DIV_W-1:0]  rx_cnt;
  logic              rx_run;
  logic              rx_first;
  logic              rx_tick;

  logic [DIV_W-1:0]  period_last;
  logic [DIV_W-1:0]  half_last;
  logic [DIV_W-1:0]  rx_target;
  logic              both_idle;

  assign pend_div    = div_lut(pend_code);
  assign period_last = divisor - DIV_W'(1);
  assign half_last   = (divisor >> 1) - DIV_W'(1);
  assign rx_target   = rx_first ? half_last : period_last;
  assign both_idle   = !bus.tx_en && !bus.rx_en;

  // Config FSM: capture requests, wait for both engines idle, then commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pend_code <= RESET_BAUD;
      baud_cur  <= RESET_BAUD;
      divisor   <= div_lut(RESET_BAUD);
      cfg_pend  <= 1'b0;
      cfg_ack   <= 1'b0;
    end else begin
      cfg_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.baud_wr) begin
            pend_code <= bus.baud;
            state     <= PEND;
            cfg_pend  <= 1'b1;
          end
        end
        PEND: begin
          if (bus.baud_wr) begin
            pend_code <= bus.baud;
          end else if (both_idle) begin
            state    <= APPLY;
            cfg_pend <= 1'b0;
          end
        end
        APPLY: begin
          baud_cur <= pend_code;
          divisor  <= pend_div;
          cfg_ack  <= 1'b1;
          if (bus.baud_wr) begin
            pend_code <= bus.baud;
            state     <= PEND;
            cfg_pend  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          cfg_pend <= 1'b0;
        end
      endcase
    end
  end

  // TX bit-period counter; the enable's first sampled cycle only arms the counter,
  // so ticks land exactly D, 2D, ... edges after the enable is first seen.
  always_ff @(posedge clk) begin
    if (reset || !bus.tx_en) begin
      tx_cnt  <= '0;
      tx_run  <= 1'b0;
      tx_tick <= 1'b0;
    end else begin
      tx_run  <= 1'b1;
      tx_tick <= 1'b0;
      if (tx_run) begin
        if (tx_cnt == period_last) begin
          tx_cnt  <= '0;
          tx_tick <= 1'b1;
        end else begin
          tx_cnt <= tx_cnt + DIV_W'(1);
        end
      end
    end
  end

  // RX sampling counter: half period to the first bit centre, full periods after.
  // A sync restarts the phase but never suppresses a tick due on the same edge.
  always_ff @(posedge clk) begin
    if (reset || !bus.rx_en) begin
      rx_cnt   <= '0;
      rx_run   <= 1'b0;
      rx_first <= 1'b1;
      rx_tick  <= 1'b0;
    end else begin
      rx_run  <= 1'b1;
      rx_tick <= rx_run && (rx_cnt == rx_target);
      if (bus.rx_sync || !rx_run) begin
        rx_cnt   <= '0;
        rx_first <= 1'b1;
      end else if (rx_cnt == rx_target) begin
        rx_cnt   <= '0;
        rx_first <= 1'b0;
      end else begin
        rx_cnt <= rx_cnt + DIV_W'(1);
      end
    end
  end

  assign bus.tx_tick  = tx_tick;
  assign bus.rx_tick  = rx_tick;
  assign bus.baud_cur = baud_cur;
  assign bus.divisor  = divisor;
  assign bus.cfg_pend = cfg_pend;
  assign bus.cfg_ack  = cfg_ack;

endmodule
